acc_writeback: RTL and testbench

ACC_WRITEBACK -- requirements
Module: acc_writeback

---
 rtl/tpu_pkg.sv | 19 +
 rtl/acc_requant.sv | 51 +++++
 rtl/acc_writeback.sv | 147 ++++++++++++++
 tb/tb_acc_writeback.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and default widths for the accumulator write-back path.
//   wb_state_t  : write-back FSM state encoding (IDLE, WR0, WR1, DONE)
//   DEF_ADDR_W  : default unified-buffer address width
//   DEF_OUT_W   : default signed width of a written element
//   ACC_W       : accumulator element width
package tpu_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_OUT_W  = 8;
  localparam int ACC_W      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2,
    DONE = 2'd3
  } wb_state_t;

endpackage

// File: rtl/acc_requant.sv
// Combinational requantizer: one 32-bit signed accumulator value in, one
// OUT_W-bit signed element out. Arithmetic right shift by SHIFT, then signed
// saturation to the OUT_W range.
// Optional feature: define ACC_WRITEBACK_RELU_EN to clamp negative inputs to
// zero before the shift; without it negative values pass through unchanged.
// Ports:
//   acc_i  : signed accumulator value
//   data_o : requantized, saturated element
module acc_requant
  import tpu_pkg::*;
#(
  parameter int SHIFT = 0,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] data_o
);

  // Largest positive OUT_W value, held at accumulator width; the most negative
  // value is its bitwise complement, which avoids any overflowing negation.
  localparam logic signed [ACC_W-1:0] MAX_V = 32'sh7fffffff >>> (ACC_W - OUT_W);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  function automatic logic signed [ACC_W-1:0] relu_fn(input logic signed [ACC_W-1:0] v);
`ifdef ACC_WRITEBACK_RELU_EN
    relu_fn = (v < 0) ? '0 : v;
`else
    relu_fn = v;
`endif
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    if (v > MAX_V) begin
      sat_fn = MAX_V[OUT_W-1:0];
    end else if (v < MIN_V) begin
      sat_fn = MIN_V[OUT_W-1:0];
    end else begin
      sat_fn = v[OUT_W-1:0];
    end
  endfunction

  logic signed [ACC_W-1:0] pre_v;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    pre_v   = relu_fn(acc_i);
    shifted = pre_v >>> SHIFT;
    data_o  = sat_fn(shifted);
  end

endmodule

// File: rtl/acc_writeback.sv
// Accumulator write-back: on a rising edge of the accumulator-full flag, the
// two accumulator results and the destination address are captured, then
// written to the unified buffer as two requantized elements (base, base+1)
// under a valid/ready handshake, followed by a one-cycle done pulse.
// Optional feature: ACC_WRITEBACK_RELU_EN enables ReLU in the requantizers.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   acc_mem_0, acc_mem_1  : signed accumulator results (elements 0 and 1)
//   full                  : accumulator-full level flag
//   base_addr             : destination address of element 0
//   ub_wr_ready           : unified buffer accepts the write this cycle
//   ub_wr_en/addr/data    : write request, address and requantized data
//   busy                  : FSM not in IDLE
//   done                  : one-cycle pulse after both writes are accepted
//   overrun               : sticky, a full rising edge arrived while busy
module acc_writeback
  import tpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [ACC_W-1:0] acc_mem_0,
  input  logic signed [ACC_W-1:0] acc_mem_1,
  input  logic                    full,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    ub_wr_ready,
  output logic                    ub_wr_en,
  output logic [ADDR_W-1:0]       ub_wr_addr,
  output logic signed [OUT_W-1:0] ub_wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  wb_state_t               state_q;
  logic                    full_q;
  logic                    armed_q;
  logic                    overrun_q;
  logic                    en_q;
  logic                    done_q;
  logic signed [ACC_W-1:0] hold0_q;
  logic signed [ACC_W-1:0] hold1_q;
  logic [ADDR_W-1:0]       base_q;
  logic [ADDR_W-1:0]       addr_q;
  logic signed [OUT_W-1:0] data_q;

  logic signed [OUT_W-1:0] rq0;
  logic signed [OUT_W-1:0] rq1;
  logic                    full_rise;
  logic                    accept;

  acc_requant #(.SHIFT(SHIFT), .OUT_W(OUT_W)) u_rq0 (
    .acc_i  (hold0_q),
    .data_o (rq0)
  );

  acc_requant #(.SHIFT(SHIFT), .OUT_W(OUT_W)) u_rq1 (
    .acc_i  (hold1_q),
    .data_o (rq1)
  );

  // armed_q blocks the first edge after reset: full_q is forced low during
  // reset, so a full that is already high at release would otherwise look
  // like a fresh rising edge.
  assign full_rise = armed_q & full & ~full_q;
  assign accept    = en_q & ub_wr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      full_q    <= 1'b0;
      armed_q   <= 1'b0;
      overrun_q <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      hold0_q   <= '0;
      hold1_q   <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      full_q  <= full;
      armed_q <= 1'b1;

      if (full_rise && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          en_q   <= 1'b0;
          done_q <= 1'b0;
          if (full_rise) begin
            hold0_q <= acc_mem_0;
            hold1_q <= acc_mem_1;
            base_q  <= base_addr;
            state_q <= WR0;
          end
        end

        // The first WR0 cycle loads the output registers from the holding
        // registers; the request becomes visible on the following cycle.
        WR0: begin
          en_q <= 1'b1;
          if (accept) begin
            addr_q  <= base_q + ADDR_W'(1);
            data_q  <= rq1;
            state_q <= WR1;
          end else begin
            addr_q <= base_q;
            data_q <= rq0;
          end
        end

        WR1: begin
          if (accept) begin
            en_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          en_q    <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ub_wr_en   = en_q;
  assign ub_wr_addr = addr_q;
  assign ub_wr_data = data_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_acc_writeback.sv
module tb_acc_writeback;

  logic               clk = 1'b0;
  logic               reset;
  logic               full;
  logic               ready;
  logic signed [31:0] acc_mem_0;
  logic signed [31:0] acc_mem_1;
  logic [7:0]         base_addr;

  logic               en0, en1, busy0, busy1, done0, done1, ovr0, ovr1;
  logic [7:0]         addr0, addr1;
  logic signed [7:0]  data0, data1;

  logic               en_a[2];
  logic               busy_a[2];
  logic               done_a[2];
  logic               ovr_a[2];
  logic [7:0]         addr_a[2];
  logic signed [7:0]  data_a[2];

  assign en_a[0]   = en0;   assign en_a[1]   = en1;
  assign busy_a[0] = busy0; assign busy_a[1] = busy1;
  assign done_a[0] = done0; assign done_a[1] = done1;
  assign ovr_a[0]  = ovr0;  assign ovr_a[1]  = ovr1;
  assign addr_a[0] = addr0; assign addr_a[1] = addr1;
  assign data_a[0] = data0; assign data_a[1] = data1;

  acc_writeback #(.ADDR_W(8), .OUT_W(8), .SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .acc_mem_0(acc_mem_0), .acc_mem_1(acc_mem_1),
    .full(full), .base_addr(base_addr), .ub_wr_ready(ready),
    .ub_wr_en(en0), .ub_wr_addr(addr0), .ub_wr_data(data0),
    .busy(busy0), .done(done0), .overrun(ovr0)
  );

  acc_writeback #(.ADDR_W(8), .OUT_W(8), .SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .acc_mem_0(acc_mem_0), .acc_mem_1(acc_mem_1),
    .full(full), .base_addr(base_addr), .ub_wr_ready(ready),
    .ub_wr_en(en1), .ub_wr_addr(addr1), .ub_wr_data(data1),
    .busy(busy1), .done(done1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ovr_exp  = 0;
  int rdy_mode = 0;
  int full_mode = 0;
  int rdy_pat[64];
  int full_pat[64];

  typedef struct {
    int         a0;
    int         a1;
    logic [7:0] base;
    int         e0s0;
    int         e1s0;
    int         e0s2;
    int         e1s2;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference requantization: optional ReLU, arithmetic shift, clamp to int8.
  function automatic int rq(input int x, input int sh);
    int v;
    v = x;
`ifdef ACC_WRITEBACK_RELU_EN
    if (v < 0) v = 0;
`endif
    v = v >>> sh;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_en", tag, d),   int'(en_a[d]),   0);
      chk($sformatf("%s_d%0d_addr", tag, d), int'(addr_a[d]), 0);
      chk($sformatf("%s_d%0d_data", tag, d), int'(data_a[d]), 0);
      chk($sformatf("%s_d%0d_busy", tag, d), int'(busy_a[d]), 0);
      chk($sformatf("%s_d%0d_done", tag, d), int'(done_a[d]), 0);
      chk($sformatf("%s_d%0d_ovr", tag, d),  int'(ovr_a[d]),  0);
    end
  endtask

  task automatic idle_chk(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("%s_c%0d_d%0d_en", tag, i, d),   int'(en_a[d]),   0);
        chk($sformatf("%s_c%0d_d%0d_busy", tag, i, d), int'(busy_a[d]), 0);
        chk($sformatf("%s_c%0d_d%0d_done", tag, i, d), int'(done_a[d]), 0);
        chk($sformatf("%s_c%0d_d%0d_ovr", tag, i, d),  int'(ovr_a[d]),  ovr_exp);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    full  = 1'b0;
    ready = 1'b0;
    #1;
    chk_zero("rst");
    ovr_exp = 0;
    @(negedge clk);
    reset = 1'b0;
    idle_chk(2, "post_rst");
  endtask

  // One capture-and-write transaction. Called at a negedge with the DUT idle
  // and full low in the previous cycle. Cycle k is sampled at the negedge
  // after the k-th rising clock edge following the full rise.
  task automatic run_txn(input int a0, input int a1, input logic [7:0] base,
                         input int x0s0, input int x1s0, input int x0s2, input int x1s2,
                         output int done_k);
    int w, pf, f, r;
    int xe0[2], xe1[2];
    logic [7:0] ea;
    bit finished;
    xe0[0] = x0s0; xe1[0] = x1s0; xe0[1] = x0s2; xe1[1] = x1s2;
    acc_mem_0 = a0; acc_mem_1 = a1; base_addr = base;
    full  = 1'b1;
    ready = 1'b1;
    pf = 1;
    w  = 0;
    done_k = -1;
    finished = 1'b0;
    for (int k = 1; k < 60; k++) begin
      @(posedge clk); @(negedge clk);
      ea = base + 8'(w);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("en_c%0d_d%0d", k, d),   int'(en_a[d]),   (w < 2 && k >= 2) ? 1 : 0);
        chk($sformatf("busy_c%0d_d%0d", k, d), int'(busy_a[d]), (w < 3) ? 1 : 0);
        chk($sformatf("done_c%0d_d%0d", k, d), int'(done_a[d]), (w == 2) ? 1 : 0);
        chk($sformatf("ovr_c%0d_d%0d", k, d),  int'(ovr_a[d]),  ovr_exp);
        if (w < 2 && k >= 2) begin
          chk($sformatf("addr_c%0d_d%0d", k, d), int'(addr_a[d]), int'(ea));
          chk($sformatf("data_c%0d_d%0d", k, d), int'(data_a[d]), (w == 0) ? xe0[d] : xe1[d]);
        end
      end
      if (w == 2) done_k = k;
      if (w == 3) begin
        finished = 1'b1;
        break;
      end
      case (rdy_mode)
        0:       r = 1;
        1:       r = int'($urandom_range(0, 1));
        default: r = rdy_pat[k];
      endcase
      if (w >= 2) begin
        f = (full_mode == 3) ? 1 : 0;
      end else begin
        case (full_mode)
          1:       f = ($urandom_range(0, 3) != 0) ? 1 : 0;
          2:       f = full_pat[k];
          default: f = 1;
        endcase
      end
      ready = (r != 0);
      full  = (f != 0);
      acc_mem_0 = $urandom;
      acc_mem_1 = $urandom;
      base_addr = 8'($urandom);
      if (f != 0 && pf == 0) ovr_exp = 1;
      pf = f;
      if (w == 2) w = 3;
      else if (k >= 2 && r != 0) w = w + 1;
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout actual=state%0d expected=complete", w);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int dk;
    int a0, a1;
    reset = 1'b1; full = 1'b0; ready = 1'b0;
    acc_mem_0 = '0; acc_mem_1 = '0; base_addr = '0;

`ifdef ACC_WRITEBACK_RELU_EN
    tbl[0] = '{5, 100, 8'h10, 5, 100, 1, 25};
    tbl[1] = '{300, -300, 8'h20, 127, 0, 75, 0};
    tbl[2] = '{-9, 7, 8'hFF, 0, 7, 0, 1};
    tbl[3] = '{32'h80000000, 32'h7fffffff, 8'h80, 0, 127, 0, 127};
    tbl[4] = '{-1, 128, 8'h00, 0, 127, 0, 32};
`else
    tbl[0] = '{5, 100, 8'h10, 5, 100, 1, 25};
    tbl[1] = '{300, -300, 8'h20, 127, -128, 75, -75};
    tbl[2] = '{-9, 7, 8'hFF, -9, 7, -3, 1};
    tbl[3] = '{32'h80000000, 32'h7fffffff, 8'h80, -128, 127, -128, 127};
    tbl[4] = '{-1, 128, 8'h00, -1, 127, -1, 32};
`endif

    do_reset();

    // Directed table, ready always high: done exactly 4 cycles after the edge.
    for (int i = 0; i < 5; i++) begin
      rdy_mode  = 0;
      full_mode = (i == 0) ? 3 : 0;
      run_txn(tbl[i].a0, tbl[i].a1, tbl[i].base,
              tbl[i].e0s0, tbl[i].e1s0, tbl[i].e0s2, tbl[i].e1s2, dk);
      chk($sformatf("tbl%0d_done_latency", i), dk, 4);
      if (i == 0) begin
        // full stays high after the transfer: no second capture
        idle_chk(4, "full_held");
        full = 1'b0;
        idle_chk(1, "full_low");
      end
    end

    // Backpressure: ready low for 3 cycles in WR0.
    for (int k = 0; k < 64; k++) begin
      rdy_pat[k]  = (k >= 2 && k <= 4) ? 0 : 1;
      full_pat[k] = 1;
    end
    rdy_mode = 2; full_mode = 0;
    run_txn(11, -22, 8'h40, rq(11, 0), rq(-22, 0), rq(11, 2), rq(-22, 2), dk);
    chk("bp_done_latency", dk, 7);

    // Overrun: full falls and rises while WR1 is stalled.
    for (int k = 0; k < 64; k++) begin
      rdy_pat[k]  = (k == 3 || k == 4) ? 0 : 1;
      full_pat[k] = (k == 3) ? 0 : 1;
    end
    rdy_mode = 2; full_mode = 2;
    run_txn(77, -5, 8'h33, rq(77, 0), rq(-5, 0), rq(77, 2), rq(-5, 2), dk);
    chk("ovr_done_latency", dk, 6);
    chk("ovr_sticky_d0", int'(ovr0), 1);
    idle_chk(2, "ovr_idle");

    // Mid-transfer reset in WR1 with full still high afterwards.
    @(negedge clk);
    acc_mem_0 = 1234; acc_mem_1 = -4321; base_addr = 8'h50;
    full = 1'b1; ready = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("mr_wr0_en", int'(en0), 1);
    chk("mr_wr0_addr", int'(addr0), 8'h50);
    @(posedge clk); @(negedge clk);
    chk("mr_wr1_en", int'(en0), 1);
    chk("mr_wr1_addr", int'(addr0), 8'h51);
    ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_zero("mid_rst");
    ovr_exp = 0;
    @(negedge clk);
    reset = 1'b0;
    ready = 1'b1;
    idle_chk(5, "after_mid_rst");
    full = 1'b0;
    idle_chk(1, "mr_full_low");
    rdy_mode = 0; full_mode = 0;
    run_txn(-100, 50, 8'h01, rq(-100, 0), rq(50, 0), rq(-100, 2), rq(50, 2), dk);
    chk("mr_recapture_latency", dk, 4);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       begin a0 = int'($urandom_range(0, 1000)) - 500;  a1 = int'($urandom_range(0, 1000)) - 500;  end
        1:       begin a0 = $urandom;                             a1 = $urandom;                             end
        default: begin a0 = int'($urandom_range(0, 4000)) - 2000; a1 = int'($urandom_range(0, 4000)) - 2000; end
      endcase
      rdy_mode = 1; full_mode = 1;
      run_txn(a0, a1, 8'($urandom), rq(a0, 0), rq(a1, 0), rq(a0, 2), rq(a1, 2), dk);
      if (i % 10 == 9) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
